// File: rtl/regfile_pkg.sv
// Shared constants and types for the 16-entry RV32E register file.
package regfile_pkg;
    localparam int REG_ADDR_W = 4;
    localparam int NUM_REGS   = 16;
    localparam int ZERO_REG   = 0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/mux16.sv
// Generic 16:1 word multiplexer library cell.
module mux16 #(
    parameter int N = 32
) (
    input  logic [15:0][N-1:0] i_din,
    input  logic [3:0]         i_sel,
    output logic [N-1:0]       o_dout
);
    assign o_dout = i_din[i_sel];
endmodule

// File: rtl/register_en.sv
// N-bit storage register with asynchronous active-low clear and load enable.
module register_en #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_q
);
    logic [N-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/regfile16.sv
// Two-read / one-write register file, x0 hardwired to zero, with a debug write counter.
module regfile16
    import regfile_pkg::*;
#(
    parameter int N = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_ena,
    input  reg_addr_t        rd_addr,
    input  logic [N-1:0]     rd_data,
    input  reg_addr_t        rs1_addr,
    input  reg_addr_t        rs2_addr,
    output logic [N-1:0]     rs1_data,
    output logic [N-1:0]     rs2_data,
    output logic [7:0]       wr_count
);
    localparam int NUM_ENTRIES = NUM_REGS;

    logic [NUM_ENTRIES-1:0]        w_load;
    logic [NUM_ENTRIES-1:0][N-1:0] w_regs;
    logic                          w_accept;
    logic [7:0]                    r_wr_count;

    // One-hot load decode; the x0 lane never loads so x0 writes are rejected here.
    assign w_load[ZERO_REG] = 1'b0;
    assign w_regs[ZERO_REG] = '0;

    generate
        for (genvar gi = 1; gi < NUM_ENTRIES; gi++) begin : g_entry
            assign w_load[gi] = wr_ena && (rd_addr == reg_addr_t'(gi));

            register_en #(.N(N)) u_reg (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_load (w_load[gi]),
                .i_d    (rd_data),
                .o_q    (w_regs[gi])
            );
        end
    endgenerate

    assign w_accept = |w_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_count <= '0;
        end else if (w_accept) begin
            r_wr_count <= r_wr_count + 8'd1;
        end
    end

    assign wr_count = r_wr_count;

    mux16 #(.N(N)) u_mux_rs1 (
        .i_din  (w_regs),
        .i_sel  (rs1_addr),
        .o_dout (rs1_data)
    );

    mux16 #(.N(N)) u_mux_rs2 (
        .i_din  (w_regs),
        .i_sel  (rs2_addr),
        .o_dout (rs2_data)
    );
endmodule
